// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the register-based stream FIFO.
// Level is wide enough to hold d itself; pointers are never narrower than one bit.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_stream_if.sv
// Write/read handshake, status and error bundle of the stream FIFO.
// The master modport is the producer/consumer side; the FIFO itself uses slave.
interface fifo_stream_if
    import fifo_pkg::*;
#(
    parameter int w = 16,
    parameter int d = 8
);
    localparam int lw = lvl_w(d);

    logic          we;
    logic [w-1:0]  wdata;
    logic          re;
    logic [w-1:0]  rdata;
    logic          rvalid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [lw-1:0] level;
    logic          clear_err;
    logic          overflow;
    logic          underflow;

    modport master (
        output we, wdata, re, clear_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  we, wdata, re, clear_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Circular index into a d-entry store; wraps from d-1 back to 0 so any
// depth works, not just powers of two.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int d = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inc,
    output logic [ptr_w(d)-1:0] ptr
);
    localparam int pw = ptr_w(d);
    localparam logic [pw-1:0] last_c = pw'(d - 1);

    // Pointer register with explicit wrap at the last entry
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= pw'(1'b0);
        end else if (inc) begin
            if (ptr == last_c) begin
                ptr <= pw'(1'b0);
            end else begin
                ptr <= ptr + pw'(1'b1);
            end
        end else begin
            ptr <= ptr;
        end
    end

endmodule

// File: rtl/fifo_stream.sv
// Register-array FIFO with exact occupancy, programmable almost flags,
// standard or first-word-fall-through read, and sticky overflow/underflow.
module fifo_stream
    import fifo_pkg::*;
#(
    parameter int w        = 16,
    parameter int d        = 8,
    parameter int af_level = 6,
    parameter int ae_level = 2,
    parameter int fwft     = 0
) (
    input logic         clock,
    input logic         reset,
    fifo_stream_if.slave bus
);
    localparam int lw = lvl_w(d);
    localparam int pw = ptr_w(d);

    if (d < 2) begin : g_bad_d
        $error("fifo_stream: d must be >= 2");
    end
    if ((af_level < 1) || (af_level > d)) begin : g_bad_af
        $error("fifo_stream: af_level must be within 1..d");
    end
    if ((ae_level < 0) || (ae_level > d - 1)) begin : g_bad_ae
        $error("fifo_stream: ae_level must be within 0..d-1");
    end
    if ((fwft != 0) && (fwft != 1)) begin : g_bad_mode
        $error("fifo_stream: fwft must be 0 or 1");
    end

    logic [pw-1:0] wptr_s;
    logic [pw-1:0] rptr_s;
    logic [lw-1:0] level_r;
    logic [w-1:0]  mem_r [d];
    logic          full_s;
    logic          empty_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          overflow_r;
    logic          underflow_r;

    // Status decode and acceptance; a full FIFO takes a write only alongside a read
    always_comb begin
        full_s   = (level_r == lw'(d));
        empty_s  = (level_r == lw'(1'b0));
        rd_acc_s = bus.re && !empty_s;
        wr_acc_s = bus.we && (!full_s || rd_acc_s);
    end

    fifo_ptr #(.d(d)) u_wptr (.clock(clock), .reset(reset), .inc(wr_acc_s), .ptr(wptr_s));
    fifo_ptr #(.d(d)) u_rptr (.clock(clock), .reset(reset), .inc(rd_acc_s), .ptr(rptr_s));

    // Storage write; contents are deliberately left out of reset
    always_ff @(posedge clock) begin
        if (wr_acc_s) begin
            mem_r[wptr_s] <= bus.wdata;
        end
    end

    // Occupancy tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r <= lw'(1'b0);
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_r <= level_r + lw'(1'b1);
                2'b01:   level_r <= level_r - lw'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky error flags; a new refusal beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.we && !wr_acc_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clear_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (bus.re && !rd_acc_s) begin
                underflow_r <= 1'b1;
            end else if (bus.clear_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (level_r >= lw'(af_level));
    assign bus.almost_empty = (level_r <= lw'(ae_level));
    assign bus.level        = level_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    if (fwft == int'(FIFO_FWFT)) begin : g_fwft
        // Head of queue presented directly; zero while empty
        always_comb begin
            if (empty_s) begin
                bus.rdata  = {w{1'b0}};
                bus.rvalid = 1'b0;
            end else begin
                bus.rdata  = mem_r[rptr_s];
                bus.rvalid = 1'b1;
            end
        end
    end else begin : g_std
        logic [w-1:0] rdata_r;
        logic         rvalid_r;

        // Registered read: data captured at the accepting edge, held otherwise
        always_ff @(posedge clock) begin
            if (reset) begin
                rdata_r  <= {w{1'b0}};
                rvalid_r <= 1'b0;
            end else begin
                rvalid_r <= rd_acc_s;
                if (rd_acc_s) begin
                    rdata_r <= mem_r[rptr_s];
                end else begin
                    rdata_r <= rdata_r;
                end
            end
        end

        assign bus.rdata  = rdata_r;
        assign bus.rvalid = rvalid_r;
    end

endmodule

// File: tb/tb_fifo_stream.sv
// Scoreboard bench: three FIFO instances (standard d=5, FWFT d=4, flag-focused d=8).
module tb_fifo_stream;
    import fifo_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fifo_stream_if #(.w(16), .d(5)) s_if ();
    fifo_stream_if #(.w(16), .d(4)) f_if ();
    fifo_stream_if #(.w(16), .d(8)) g_if ();

    fifo_stream #(.w(16), .d(5), .af_level(4), .ae_level(1), .fwft(0))
        u_std (.clock(clk), .reset(rst), .bus(s_if));
    fifo_stream #(.w(16), .d(4), .af_level(3), .ae_level(1), .fwft(1))
        u_fwft (.clock(clk), .reset(rst), .bus(f_if));
    fifo_stream #(.w(16), .d(8), .af_level(6), .ae_level(2), .fwft(0))
        u_flg (.clock(clk), .reset(rst), .bus(g_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the standard instance
    logic [15:0] sb_q[$];
    int          m_lvl;
    logic        m_rv;
    logic        m_ovf;
    logic        m_unf;

    // Drive one cycle on the standard instance and advance its model
    task automatic std_step(input logic we, input logic [15:0] wd, input logic re, input logic ce);
        logic rd_acc;
        logic wr_acc;
        s_if.we = we; s_if.wdata = wd; s_if.re = re; s_if.clear_err = ce;
        rd_acc = re && (m_lvl != 0);
        wr_acc = we && ((m_lvl != 5) || rd_acc);
        if (we && !wr_acc) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
        if (re && !rd_acc) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
        m_rv = rd_acc;
        if (wr_acc) sb_q.push_back(wd);
        if (wr_acc && !rd_acc) m_lvl++;
        else if (rd_acc && !wr_acc) m_lvl--;
        @(posedge clk); #1;
        s_if.we = 1'b0; s_if.re = 1'b0; s_if.clear_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete(); m_lvl = 0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        checks++;
        if (s_if.level !== 3'd0 || s_if.empty !== 1'b1 || s_if.full !== 1'b0 ||
            s_if.almost_empty !== 1'b1 || s_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: level=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
                     s_if.level, s_if.empty, s_if.full, s_if.almost_empty, s_if.almost_full);
        end
        checks++;
        if (s_if.rvalid !== 1'b0 || s_if.rdata !== 16'h0000 || s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rvalid=%b rdata=%h ovf=%b unf=%b want 0 0000 0 0",
                     s_if.rvalid, s_if.rdata, s_if.overflow, s_if.underflow);
        end
        checks++;
        if (f_if.rvalid !== 1'b0 || f_if.rdata !== 16'h0000 || g_if.almost_empty !== 1'b1 || g_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_other: fwft rvalid=%b rdata=%h flg ae=%b af=%b want 0 0000 1 0",
                     f_if.rvalid, f_if.rdata, g_if.almost_empty, g_if.almost_full);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp_d;
        for (int i = 1; i <= 6; i++) begin
            std_step(1'b1, 16'(i), 1'b0, 1'b0);
            checks++;
            if (s_if.level !== 3'(m_lvl) || s_if.full !== (m_lvl == 5) ||
                s_if.almost_full !== (m_lvl >= 4) || s_if.overflow !== m_ovf) begin
                errors++;
                $display("FAIL fill_%0d: level=%0d full=%b af=%b ovf=%b want %0d %b %b %b", i,
                         s_if.level, s_if.full, s_if.almost_full, s_if.overflow,
                         m_lvl, (m_lvl == 5), (m_lvl >= 4), m_ovf);
            end
        end
        checks++;
        if (s_if.overflow !== 1'b1 || s_if.level !== 3'd5) begin
            errors++;
            $display("FAIL sixth_write: ovf=%b level=%0d want 1 5", s_if.overflow, s_if.level);
        end
        for (int i = 1; i <= 6; i++) begin
            std_step(1'b0, 16'h0000, (i <= 5), 1'b0);
            checks++;
            if (s_if.rvalid !== m_rv) begin
                errors++;
                $display("FAIL drain_rvalid_%0d: rvalid=%b want %b", i, s_if.rvalid, m_rv);
            end else if (s_if.rvalid === 1'b1) begin
                exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
                checks++;
                if (s_if.rdata !== exp_d || exp_d !== 16'(i)) begin
                    errors++;
                    $display("FAIL drain_data_%0d: rdata=%h want %h", i, s_if.rdata, exp_d);
                end
            end
        end
        checks++;
        if (s_if.empty !== 1'b1 || s_if.level !== 3'd0 || s_if.almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL drained_empty: empty=%b level=%0d ae=%b want 1 0 1", s_if.empty, s_if.level, s_if.almost_empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d;
        logic [15:0] order [5];
        order[0] = 16'h0004; order[1] = 16'h0005; order[2] = 16'h00A0; order[3] = 16'h00A1; order[4] = 16'h00A2;
        std_step(1'b0, 16'h0000, 1'b0, 1'b1);
        checks++;
        if (s_if.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_clear: ovf=%b want 0", s_if.overflow);
        end
        for (int i = 1; i <= 5; i++) std_step(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            std_step(1'b1, 16'h00A0 + 16'(i), 1'b1, 1'b0);
            exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
            checks++;
            if (s_if.level !== 3'd5 || s_if.overflow !== 1'b0 || s_if.rvalid !== 1'b1 || s_if.rdata !== exp_d) begin
                errors++;
                $display("FAIL b2b_rw_%0d: level=%0d ovf=%b rvalid=%b rdata=%h want 5 0 1 %h",
                         i, s_if.level, s_if.overflow, s_if.rvalid, s_if.rdata, exp_d);
            end
        end
        for (int i = 0; i < 5; i++) begin
            std_step(1'b0, 16'h0000, 1'b1, 1'b0);
            exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
            checks++;
            if (s_if.rvalid !== 1'b1 || s_if.rdata !== exp_d || exp_d !== order[i]) begin
                errors++;
                $display("FAIL b2b_drain_%0d: rvalid=%b rdata=%h want 1 %h", i, s_if.rvalid, s_if.rdata, order[i]);
            end
        end
    endtask

    task automatic test_clear_err();
        for (int i = 0; i < 6; i++) std_step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        checks++;
        if (s_if.overflow !== 1'b1) begin
            errors++;
            $display("FAIL err_set: ovf=%b want 1", s_if.overflow);
        end
        std_step(1'b0, 16'h0000, 1'b0, 1'b1);
        checks++;
        if (s_if.overflow !== m_ovf || m_ovf !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_alone: ovf=%b want 0", s_if.overflow);
        end
        std_step(1'b1, 16'h0DEF, 1'b0, 1'b1);
        checks++;
        if (s_if.overflow !== 1'b1 || s_if.level !== 3'd5) begin
            errors++;
            $display("FAIL err_set_wins: ovf=%b level=%0d want 1 5", s_if.overflow, s_if.level);
        end
        for (int i = 0; i < 5; i++) begin
            std_step(1'b0, 16'h0000, 1'b1, 1'b0);
            checks++;
            if (s_if.rvalid !== 1'b1 || s_if.rdata !== sb_q[0]) begin
                errors++;
                $display("FAIL err_drain_%0d: rvalid=%b rdata=%h want 1 %h", i, s_if.rvalid, s_if.rdata, sb_q[0]);
            end
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        std_step(1'b0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (s_if.underflow !== 1'b1 || s_if.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL unf_set: unf=%b rvalid=%b want 1 0", s_if.underflow, s_if.rvalid);
        end
        for (int i = 0; i < 3; i++) std_step(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0);
        std_step(1'b0, 16'h0000, 1'b1, 1'b0);
        std_step(1'b1, 16'h0C03, 1'b0, 1'b0);
        rst = 1'b1; s_if.we = 1'b1; s_if.re = 1'b1; s_if.wdata = 16'h0FFF;
        @(posedge clk); #1;
        rst = 1'b0; s_if.we = 1'b0; s_if.re = 1'b0;
        sb_q.delete(); m_lvl = 0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        checks++;
        if (s_if.level !== 3'd0 || s_if.empty !== 1'b1 || s_if.rvalid !== 1'b0 || s_if.rdata !== 16'h0000 ||
            s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d e=%b rv=%b rd=%h ovf=%b unf=%b want 0 1 0 0000 0 0",
                     s_if.level, s_if.empty, s_if.rvalid, s_if.rdata, s_if.overflow, s_if.underflow);
        end
        std_step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        std_step(1'b0, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (s_if.rvalid !== 1'b1 || s_if.rdata !== 16'hBEEF || s_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_rd: rvalid=%b rdata=%h empty=%b want 1 beef 1", s_if.rvalid, s_if.rdata, s_if.empty);
        end
    endtask

    task automatic test_fwft();
        logic [15:0] fq[$];
        f_if.we = 1'b1; f_if.wdata = 16'h1234;
        @(posedge clk); #1;
        f_if.we = 1'b0;
        checks++;
        if (f_if.rvalid !== 1'b1 || f_if.rdata !== 16'h1234) begin
            errors++;
            $display("FAIL fwft_first: rvalid=%b rdata=%h want 1 1234", f_if.rvalid, f_if.rdata);
        end
        f_if.re = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (f_if.rvalid !== 1'b0 || f_if.rdata !== 16'h0000 || f_if.underflow !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop: rvalid=%b rdata=%h unf=%b want 0 0000 0", f_if.rvalid, f_if.rdata, f_if.underflow);
        end
        @(posedge clk); #1;
        f_if.re = 1'b0;
        checks++;
        if (f_if.underflow !== 1'b1) begin
            errors++;
            $display("FAIL fwft_unf: unf=%b want 1", f_if.underflow);
        end
        for (int i = 0; i < 5; i++) begin
            f_if.we = 1'b1; f_if.wdata = 16'h5A00 + 16'(i);
            if (fq.size() < 4) fq.push_back(f_if.wdata);
            @(posedge clk); #1;
        end
        f_if.we = 1'b0;
        checks++;
        if (f_if.full !== 1'b1 || f_if.overflow !== 1'b1 || f_if.level !== 3'd4) begin
            errors++;
            $display("FAIL fwft_full: full=%b ovf=%b level=%0d want 1 1 4", f_if.full, f_if.overflow, f_if.level);
        end
        while (fq.size() != 0) begin
            checks++;
            if (f_if.rvalid !== 1'b1 || f_if.rdata !== fq[0]) begin
                errors++;
                $display("FAIL fwft_head: rvalid=%b rdata=%h want 1 %h", f_if.rvalid, f_if.rdata, fq[0]);
            end
            f_if.re = 1'b1;
            @(posedge clk); #1;
            f_if.re = 1'b0;
            void'(fq.pop_front());
        end
        checks++;
        if (f_if.rvalid !== 1'b0 || f_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_empty: rvalid=%b empty=%b want 0 1", f_if.rvalid, f_if.empty);
        end
    endtask

    task automatic test_flags();
        logic [15:0] gq[$];
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            g_if.we = (i < 6); g_if.re = (i >= 6); g_if.wdata = 16'h7700 + 16'(i);
            if (i < 6) gq.push_back(g_if.wdata);
            @(posedge clk); #1;
            g_if.we = 1'b0; g_if.re = 1'b0;
            n = (i < 6) ? n + 1 : n - 1;
            checks++;
            if (g_if.level !== 4'(n) || g_if.almost_full !== (n >= 6) || g_if.almost_empty !== (n <= 2)) begin
                errors++;
                $display("FAIL flags_%0d: level=%0d af=%b ae=%b want %0d %b %b", i,
                         g_if.level, g_if.almost_full, g_if.almost_empty, n, (n >= 6), (n <= 2));
            end
            if (i >= 6) begin
                checks++;
                if (g_if.rvalid !== 1'b1 || g_if.rdata !== gq[0]) begin
                    errors++;
                    $display("FAIL flags_rd_%0d: rvalid=%b rdata=%h want 1 %h", i, g_if.rvalid, g_if.rdata, gq[0]);
                end
                void'(gq.pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        s_if.we = 1'b0; s_if.re = 1'b0; s_if.wdata = 16'h0000; s_if.clear_err = 1'b0;
        f_if.we = 1'b0; f_if.re = 1'b0; f_if.wdata = 16'h0000; f_if.clear_err = 1'b0;
        g_if.we = 1'b0; g_if.re = 1'b0; g_if.wdata = 16'h0000; g_if.clear_err = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_clear_err();
        test_reset_mid();
        test_fwft();
        test_flags();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
